// File: rtl/fifo_rd_packer_if.sv
// Bundles the FIFO read port, the flush request and the downstream word
// handshake of fifo_rd_packer. The master modport is the packer's view and
// the slave modport is the environment's view (FIFO plus word consumer).
// out_parity exists only when FIFO_RD_PACKER_PARITY_EN is defined.
interface fifo_rd_packer_if #(
   parameter int DATA_W = 4,
   parameter int PACK_N = 4
);
   localparam int OUT_W = DATA_W * PACK_N;
   localparam int CNT_W = $clog2(PACK_N + 1);

   logic              empty;
   logic              r_en;
   logic [DATA_W-1:0] r_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic [CNT_W-1:0]  out_cnt;
`ifdef FIFO_RD_PACKER_PARITY_EN
   logic              out_parity;

   modport master (
      input  empty, r_data, flush, out_ready,
      output r_en, out_valid, out_data, out_cnt, out_parity
   );
   modport slave (
      output empty, r_data, flush, out_ready,
      input  r_en, out_valid, out_data, out_cnt, out_parity
   );
`else
   modport master (
      input  empty, r_data, flush, out_ready,
      output r_en, out_valid, out_data, out_cnt
   );
   modport slave (
      output empty, r_data, flush, out_ready,
      input  r_en, out_valid, out_data, out_cnt
   );
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-clock-domain consumer of a 4-bit async FIFO.
// Pops nibbles while the FIFO is not empty, packs PACK_N of them (first nibble
// in the low bits) into one word and offers it on a valid/ready handshake.
// A flush pulse emits the partial word zero-padded, with out_cnt = nibbles held.
// Optional feature macro: FIFO_RD_PACKER_PARITY_EN adds out_parity = ^out_data,
// registered together with out_data.
module fifo_rd_packer #(
   parameter int DATA_W = 4,
   parameter int PACK_N = 4
) (
   input logic              r_clk,
   input logic              r_rst_n,
   fifo_rd_packer_if.master bus
);
   localparam int OUT_W = DATA_W * PACK_N;
   localparam int CNT_W = $clog2(PACK_N + 1);

   // FILL: popping nibbles; HOLD: full word parked in acc waiting for the
   // output slot; FLUSH_WAIT: a flush is owed, partial word waits for the slot.
   typedef enum logic [1:0] {FILL, HOLD, FLUSH_WAIT} state_t;

   state_t            state_q, state_d;
   logic              run_q, run_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

   logic              slot_free;
   logic              flush_take;
   logic              r_en;
   logic [CNT_W:0]    in_use;
   logic [OUT_W-1:0]  acc_land;
   logic [CNT_W-1:0]  cnt_land;

   // Pop decision: a flush that will act this cycle blocks the pop so the
   // partial word is not chased by a fresh nibble.
   always_comb begin
      slot_free  = !out_valid_q || bus.out_ready;
      in_use     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pend_q};
      flush_take = bus.flush && (state_q == FILL) && (rd_pend_q || (cnt_q != '0));
      r_en       = run_q && !bus.empty && (state_q == FILL) &&
                   (in_use < (CNT_W+1)'(PACK_N)) && !flush_take;
   end

   // Accumulator image after the in-flight nibble lands at slot cnt.
   always_comb begin
      acc_land = acc_q;
      for (int i = 0; i < PACK_N; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            acc_land[i*DATA_W +: DATA_W] = bus.r_data;
         end
      end
      cnt_land = cnt_q + CNT_W'(1);
   end

   // Next-state, accumulation and output-slot loading.
   always_comb begin
      state_d     = state_q;
      run_d       = 1'b1;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      rd_pend_d   = r_en;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;

      unique case (state_q)
         FILL: begin
            if (rd_pend_q) begin
               if (cnt_land == CNT_W'(PACK_N)) begin
                  // Completion wins over a coincident flush.
                  if (slot_free) begin
                     out_data_d  = acc_land;
                     out_cnt_d   = CNT_W'(PACK_N);
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     cnt_d       = '0;
                  end else begin
                     acc_d   = acc_land;
                     cnt_d   = cnt_land;
                     state_d = HOLD;
                  end
               end else begin
                  acc_d = acc_land;
                  cnt_d = cnt_land;
                  // Nibble lands now; the owed flush is served next cycle.
                  if (flush_take) begin
                     state_d = FLUSH_WAIT;
                  end
               end
            end else if (flush_take) begin
               if (slot_free) begin
                  out_data_d  = acc_q;
                  out_cnt_d   = cnt_q;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
               end else begin
                  state_d = FLUSH_WAIT;
               end
            end
         end
         HOLD, FLUSH_WAIT: begin
            // cnt_q is PACK_N in HOLD and the partial count in FLUSH_WAIT.
            if (slot_free) begin
               out_data_d  = acc_q;
               out_cnt_d   = cnt_q;
               out_valid_d = 1'b1;
               acc_d       = '0;
               cnt_d       = '0;
               state_d     = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         state_q     <= FILL;
         run_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         rd_pend_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rd_pend_q   <= rd_pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

`ifdef FIFO_RD_PACKER_PARITY_EN
   logic out_parity_q, out_parity_d;

   // Parity follows out_data_d so it loads and holds with the word.
   always_comb begin
      out_parity_d = ^out_data_d;
   end

   // Parity register, aligned with out_data_q.
   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         out_parity_q <= 1'b0;
      end else begin
         out_parity_q <= out_parity_d;
      end
   end

   assign bus.out_parity = out_parity_q;
`endif

   assign bus.r_en      = r_en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_cnt   = out_cnt_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a queue-based FIFO model feeds nibbles, a
// queue of accepted words is compared against expected constants or the
// pushed nibble stream.
module tb_fifo_rd_packer;
   localparam int DATA_W = 4;
   localparam int PACK_N = 4;
   localparam int OUT_W  = DATA_W * PACK_N;
   localparam int CNT_W  = $clog2(PACK_N + 1);

   logic r_clk   = 1'b0;
   logic r_rst_n = 1'b0;

   fifo_rd_packer_if #(.DATA_W(DATA_W), .PACK_N(PACK_N)) bus ();

   fifo_rd_packer #(.DATA_W(DATA_W), .PACK_N(PACK_N)) dut (
      .r_clk   (r_clk),
      .r_rst_n (r_rst_n),
      .bus     (bus)
   );

   always #5 r_clk = ~r_clk;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] fifo[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [OUT_W-1:0]  wd[$];
   logic [CNT_W-1:0]  wc[$];
   logic              wp[$];
   bit                hide = 1'b0;
   int                ren_empty_viol = 0;
   int                stab_viol = 0;
   int                valid_cycles = 0;
   int                pops = 0;
   bit                held = 1'b0;
   logic [OUT_W-1:0]  held_data;
   logic [CNT_W-1:0]  held_cnt;

   task automatic set_empty();
      bus.empty = (fifo.size() == 0) || hide;
   endtask

   task automatic push(input logic [DATA_W-1:0] v);
      fifo.push_back(v);
      exp_q.push_back(v);
      set_empty();
   endtask

   task automatic clear_log();
      wd.delete();
      wc.delete();
      wp.delete();
      valid_cycles = 0;
      pops = 0;
   endtask

   // One clock: observe outputs before the edge, advance the FIFO model after.
   task automatic tick();
      bit pop;
      #1;
      pop = bus.r_en && !bus.empty;
      if (bus.r_en && bus.empty) ren_empty_viol++;
      if (bus.out_valid) valid_cycles++;
      if (held && (!bus.out_valid || bus.out_data !== held_data || bus.out_cnt !== held_cnt))
         stab_viol++;
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_cnt  = bus.out_cnt;
      if (bus.out_valid && bus.out_ready) begin
         wd.push_back(bus.out_data);
         wc.push_back(bus.out_cnt);
`ifdef FIFO_RD_PACKER_PARITY_EN
         wp.push_back(bus.out_parity);
`else
         wp.push_back(1'b0);
`endif
      end
      @(posedge r_clk);
      #1;
      if (pop && fifo.size() > 0) begin
         bus.r_data = fifo.pop_front();
         pops++;
      end else begin
         bus.r_data = DATA_W'($urandom);
      end
      set_empty();
   endtask

   task automatic test_reset();
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      repeat (2) tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
      checks++; if (bus.out_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.out_cnt); end
      checks++; if (bus.r_en !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", bus.r_en); end
      r_rst_n = 1'b1;
      #1;
      checks++; if (bus.r_en !== 1'b0) begin errors++; $display("FAIL release_ren_before_run got %b exp 0", bus.r_en); end
      tick();
      checks++; if (bus.r_en !== 1'b1) begin errors++; $display("FAIL run_ren got %b exp 1", bus.r_en); end
   endtask

   task automatic test_basic();
      clear_log();
      bus.out_ready = 1'b1;
      repeat (15) tick();
      checks++; if (wd.size() !== 1) begin errors++; $display("FAIL basic_words got %0d exp 1", wd.size()); end
      checks++; if (valid_cycles !== 1) begin errors++; $display("FAIL basic_valid_pulse got %0d exp 1", valid_cycles); end
      if (wd.size() > 0) begin
         checks++; if (wd[0] !== 16'h4321) begin errors++; $display("FAIL basic_data got %h exp 4321", wd[0]); end
         checks++; if (wc[0] !== CNT_W'(4)) begin errors++; $display("FAIL basic_cnt got %0d exp 4", wc[0]); end
`ifdef FIFO_RD_PACKER_PARITY_EN
         checks++; if (wp[0] !== 1'b1) begin errors++; $display("FAIL basic_parity got %b exp 1", wp[0]); end
`endif
      end
   endtask

   task automatic test_backpressure();
      clear_log();
      stab_viol = 0;
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) push(DATA_W'(i));
      repeat (20) tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h4321) begin errors++; $display("FAIL bp_held_data got %h exp 4321", bus.out_data); end
      checks++; if (bus.r_en !== 1'b0 || bus.empty !== 1'b0) begin
         errors++; $display("FAIL bp_hold_ren got r_en=%b empty=%b exp r_en=0 empty=0", bus.r_en, bus.empty);
      end
      checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stab_viol); end
      bus.out_ready = 1'b1;
      repeat (12) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      repeat (8) tick();
      checks++; if (wd.size() !== 3) begin errors++; $display("FAIL bp_words got %0d exp 3", wd.size()); end
      if (wd.size() == 3) begin
         checks++; if (wd[0] !== 16'h4321) begin errors++; $display("FAIL bp_word0 got %h exp 4321", wd[0]); end
         checks++; if (wd[1] !== 16'h8765) begin errors++; $display("FAIL bp_word1 got %h exp 8765", wd[1]); end
         checks++; if (wd[2] !== 16'h0009 || wc[2] !== CNT_W'(1)) begin
            errors++; $display("FAIL bp_word2 got %h/%0d exp 0009/1", wd[2], wc[2]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_flush();
      clear_log();
      bus.out_ready = 1'b1;
      push(4'hA); push(4'hB);
      repeat (6) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      repeat (5) tick();
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      repeat (10) tick();
      checks++; if (wd.size() !== 2) begin errors++; $display("FAIL flush_words got %0d exp 2", wd.size()); end
      if (wd.size() == 2) begin
         checks++; if (wd[0] !== 16'h00BA || wc[0] !== CNT_W'(2)) begin
            errors++; $display("FAIL flush_partial got %h/%0d exp 00BA/2", wd[0], wc[0]);
         end
`ifdef FIFO_RD_PACKER_PARITY_EN
         checks++; if (wp[0] !== 1'b1) begin errors++; $display("FAIL flush_parity got %b exp 1", wp[0]); end
`endif
         checks++; if (wd[1] !== 16'h4321 || wc[1] !== CNT_W'(4)) begin
            errors++; $display("FAIL flush_next_word got %h/%0d exp 4321/4", wd[1], wc[1]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_flush_inflight();
      int n;
      clear_log();
      bus.out_ready = 1'b1;
      push(4'hA); push(4'hB); push(4'hC);
      n = 0;
      while (pops < 2 && n < 10) begin
         tick();
         n++;
      end
      checks++; if (pops < 2) begin errors++; $display("FAIL inflight_pops got %0d exp 2", pops); end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      repeat (6) tick();
      push(4'h1); push(4'h2); push(4'h3);
      repeat (10) tick();
      checks++; if (wd.size() !== 2) begin errors++; $display("FAIL inflight_words got %0d exp 2", wd.size()); end
      if (wd.size() == 2) begin
         checks++; if (wd[0] !== 16'h00BA || wc[0] !== CNT_W'(2)) begin
            errors++; $display("FAIL inflight_partial got %h/%0d exp 00BA/2", wd[0], wc[0]);
         end
         checks++; if (wd[1] !== 16'h321C || wc[1] !== CNT_W'(4)) begin
            errors++; $display("FAIL inflight_next got %h/%0d exp 321C/4", wd[1], wc[1]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [OUT_W-1:0] ew;
      clear_log();
      exp_q.delete();
      ren_empty_viol = 0;
      stab_viol = 0;
      for (int c = 0; c < 1000; c++) begin
         if ($urandom_range(0, 2) == 0 && fifo.size() < 6) push(DATA_W'($urandom));
         hide = ($urandom_range(0, 2) == 0);
         bus.out_ready = $urandom_range(0, 1) == 1;
         set_empty();
         tick();
      end
      hide = 1'b0;
      bus.out_ready = 1'b1;
      set_empty();
      repeat (30) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      repeat (10) tick();
      checks++; if (ren_empty_viol !== 0) begin errors++; $display("FAIL rand_ren_empty got %0d exp 0", ren_empty_viol); end
      checks++; if (stab_viol !== 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stab_viol); end
      checks++; if (wd.size() < 20) begin errors++; $display("FAIL rand_word_count got %0d exp >=20", wd.size()); end
      for (int i = 0; i < wd.size(); i++) begin
         ew = '0;
         for (int j = 0; j < int'(wc[i]); j++) begin
            if (exp_q.size() > 0) ew[j*DATA_W +: DATA_W] = exp_q.pop_front();
         end
         checks++; if (wd[i] !== ew) begin errors++; $display("FAIL rand_word%0d got %h exp %h", i, wd[i], ew); end
         if (i < wd.size() - 1) begin
            checks++; if (wc[i] !== CNT_W'(PACK_N)) begin errors++; $display("FAIL rand_cnt%0d got %0d exp %0d", i, wc[i], PACK_N); end
         end
      end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      clear_log();
      bus.out_ready = 1'b1;
      push(4'h1); push(4'h2); push(4'h3);
      repeat (6) tick();
      #2;
      r_rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_cnt !== '0) begin
         errors++; $display("FAIL midrst_outputs got %b/%h/%0d exp 0/0000/0", bus.out_valid, bus.out_data, bus.out_cnt);
      end
      checks++; if (bus.r_en !== 1'b0) begin errors++; $display("FAIL midrst_ren got %b exp 0", bus.r_en); end
      fifo.delete();
      exp_q.delete();
      held = 1'b0;
      push(4'h5); push(4'h6); push(4'h7); push(4'h8);
      repeat (2) tick();
      r_rst_n = 1'b1;
      #1;
      checks++; if (bus.r_en !== 1'b0) begin errors++; $display("FAIL midrst_release_ren got %b exp 0", bus.r_en); end
      repeat (15) tick();
      checks++; if (wd.size() !== 1) begin errors++; $display("FAIL midrst_words got %0d exp 1", wd.size()); end
      if (wd.size() == 1) begin
         checks++; if (wd[0] !== 16'h8765 || wc[0] !== CNT_W'(4)) begin
            errors++; $display("FAIL midrst_word got %h/%0d exp 8765/4", wd[0], wc[0]);
         end
      end
   endtask

   initial begin
      bus.empty     = 1'b1;
      bus.r_data    = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_flush();
      test_flush_inflight();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
